muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative MIPS multiply/divide unit with architectural HI/LO registers, beside the ALU in execute.
//  Takes the same register-file operands as the ALU (op1 -> a, op2 -> b).
//  Runs MULT/MULTU/DIV/DIVU over 32 iterations and holds results in HI/LO.
//  HI/LO feed the writeback mux for MFHI/MFLO. Control stalls the PC while busy is high.
// PARAMETERS
//  WIDTH  32  operand/HI/LO width; the iteration count equals WIDTH
// PORTS
//  clk     in   1      single clock; all state updates on rising edge
//  reset   in   1      synchronous, active-high
//  start   in   1      launch op; sampled only when busy==0
//  op      in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  a       in   WIDTH  rs operand (multiplicand / dividend)
//  b       in   WIDTH  rt operand (multiplier / divisor)
//  hi_we   in   1      MTHI write strobe
//  lo_we   in   1      MTLO write strobe
//  wdata   in   WIDTH  MTHI/MTLO data
//  busy    out  1      high in CALC and SIGN states
//  done    out  1      one-cycle pulse: HI/LO hold new result
//  hi      out  WIDTH  HI register (mult upper half / div remainder)
//  lo      out  WIDTH  LO register (mult lower half / div quotient)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, hi=0, lo=0; clears any in-flight op.
//  FSM states are IDLE, CALC, SIGN and DONE.
//   IDLE/DONE + start -> CALC: latch op, |a|, |b| (magnitudes for signed ops), sign flags; counter=0.
//   CALC: one shift-add (mult) or restoring shift-subtract (div) step per cycle.
//    The counter runs 0..WIDTH-1; at WIDTH-1 the next state is SIGN.
//   SIGN: apply sign correction, write hi/lo, next state DONE.
//   DONE: done=1 for exactly one cycle. Next state is CALC if start, else IDLE.
//  Latency: start sampled at edge E0, hi/lo written at E(WIDTH+1), done high during the cycle after.
//   With WIDTH=32, done is the 34th cycle after start. Back-to-back start in DONE is legal.
//  start while busy: ignored, no effect.
//  Multiply: the 2*WIDTH-bit product goes to {hi,lo}. Signed ops negate the product if sign(a)^sign(b).
//  Divide: the quotient truncates toward zero and goes to lo. The remainder goes to hi.
//   For DIV, the remainder takes the sign of the dividend.
//  Divide by zero: no trap, still full latency; lo = all ones, hi = a.
//  DIV of INT_MIN by -1: lo = INT_MIN, hi = 0 (wraps, no flag).
//  Operand magnitude: negation of INT_MIN is treated as unsigned 2^(WIDTH-1). Internal datapath is WIDTH+1 bits where needed.
//  hi_we/lo_we: write hi/lo at the edge only when busy==0. Ignored while busy.
//   Same-edge start + hi_we/lo_we in IDLE: the write takes effect, then is overwritten by the result at SIGN.
//  hi/lo hold their values between operations. Outputs are not updated during CALC.
//  Reset mid-operation: aborts at that edge. Restart requires a new start.
// TESTING
//  MULT a=-3 (0xFFFFFFFD), b=7 -> done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB
//  MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001
//  DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=7, b=2 -> lo=3, hi=1
//  DIVU a=0x1234, b=0 -> lo=0xFFFFFFFF, hi=0x1234; DIV 0x80000000 / -1 -> lo=0x80000000, hi=0
//  start pulse at cycle 5 of a running op, plus hi_we=1 wdata=0xAA while busy
//   -> both ignored; first result intact; then MTLO 0x55 in IDLE -> lo=0x55 next cycle
//  reset asserted at cycle 10 of a DIV -> next cycle busy=0, done=0, hi=lo=0; no done pulse follows

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Latency: start sampled at E0, HI/LO written at E(WIDTH+1), done pulses in the following cycle.
// Backpressure: busy holds off new starts and MTHI/MTLO writes; start while busy is dropped.
//
// Ports:
//   clk, reset      : single clock, synchronous active-high reset
//   start, op, a, b : launch MULT(00) / MULTU(01) / DIV(10) / DIVU(11) on rs=a, rt=b
//   hi_we, lo_we    : MTHI / MTLO strobes carrying wdata, honoured only while idle
//   busy, done      : busy in CALC/SIGN; done is a one-cycle pulse once HI/LO hold the result
//   hi, lo          : HI (mult upper / remainder), LO (mult lower / quotient)
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_SIGN,
        S_DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;

    // Latched operation attributes
    logic             is_div;
    logic             is_signed;
    logic             neg_a;
    logic             neg_b;

    // Shared iteration registers.
    //   mult: {acc_hi, acc_lo} is the partial product; acc_lo starts as |b| and is
    //         consumed LSB first while product bits shift in from the top.
    //   div : acc_hi is the partial remainder, acc_lo starts as |a| and collects
    //         quotient bits from the bottom.
    //   opnd: |a| for mult (multiplicand), |b| for div (divisor); held through SIGN.
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opnd;

    // Operand magnitudes at launch. Negating INT_MIN yields 2^(WIDTH-1), which is
    // exactly right when the result is read as unsigned.
    logic             in_signed;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    always_comb begin
        in_signed = ~op[0];
        a_mag     = (in_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
        b_mag     = (in_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;
    end

    // One iteration step, evaluated every cycle and used only in CALC.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH-1:0] div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        // The true difference is below the divisor, so it fits in WIDTH bits.
        div_sub   = div_shift[WIDTH-1:0] - opnd;
        step_hi   = acc_hi;
        step_lo   = acc_lo;
        if (is_div) begin
            step_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction applied in SIGN.
    logic [2*WIDTH-1:0] prod_raw;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic               res_neg;

    always_comb begin
        res_neg  = is_signed && (neg_a ^ neg_b);
        prod_raw = {acc_hi, acc_lo};
        prod_fix = res_neg ? (~prod_raw + 1'b1) : prod_raw;
        // Divide by zero forces an all-ones quotient. The restoring loop already
        // leaves |a| as the remainder, and the dividend-sign fix-up turns it back into a.
        if (opnd == '0)
            quo_fix = '1;
        else
            quo_fix = res_neg ? (~acc_lo + 1'b1) : acc_lo;
        rem_fix  = (is_signed && neg_a) ? (~acc_hi + 1'b1) : acc_hi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            cnt       <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            neg_a     <= 1'b0;
            neg_b     <= 1'b0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            opnd      <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    // MTHI/MTLO land even on a launch edge; SIGN overwrites them later.
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        state     <= S_CALC;
                        busy      <= 1'b1;
                        cnt       <= '0;
                        is_div    <= op[1];
                        is_signed <= in_signed;
                        neg_a     <= in_signed & a[WIDTH-1];
                        neg_b     <= in_signed & b[WIDTH-1];
                        acc_hi    <= '0;
                        if (op[1]) begin
                            acc_lo <= a_mag;
                            opnd   <= b_mag;
                        end else begin
                            acc_lo <= b_mag;
                            opnd   <= a_mag;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_CALC: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH-1))
                        state <= S_SIGN;
                end
                S_SIGN: begin
                    if (is_div) begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end else begin
                        hi <= prod_fix[2*WIDTH-1:WIDTH];
                        lo <= prod_fix[WIDTH-1:0];
                    end
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          drive_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   nchecks = 0;
    int   nerrs   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nchecks++;
        if (act !== req) begin
            nerrs++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: plain integer arithmetic, returns {hi, lo}.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        int     sx;
        int     sy;
        longint lx;
        longint ly;
        longint q;
        longint r;
        logic [63:0] res;
        sx = x;
        sy = y;
        lx = sx;
        ly = sy;
        res = '0;
        case (o)
            2'b00: res = lx * ly;
            2'b01: res = {32'b0, x} * {32'b0, y};
            2'b10: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else begin
                    q = lx / ly;
                    r = lx % ly;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (y == 0) res = {x, 32'hFFFF_FFFF};
                else res = {x % y, x / y};
            end
        endcase
        return res;
    endfunction

    // Scoreboard monitor
    logic        prev_busy = 1'b0;
    logic [31:0] prev_hi = '0;
    logic [31:0] prev_lo = '0;

    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 1'b0;
        end else begin
            if (prev_busy && busy) begin
                chk("hold_hi_while_busy", {32'b0, hi}, {32'b0, prev_hi});
                chk("hold_lo_while_busy", {32'b0, lo}, {32'b0, prev_lo});
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result_hi", {32'b0, hi}, {32'b0, e.hi});
                    chk("result_lo", {32'b0, lo}, {32'b0, e.lo});
                    chk("done_latency", 64'(cyc - e.drive_cyc), 64'd34);
                end
            end
            prev_busy = busy;
            prev_hi   = hi;
            prev_lo   = lo;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("wait_idle_timeout", 64'd1, 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 64'd1, 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Launch one op with a given expected {hi,lo}. mt: 0 none, 1 MTHI, 2 MTLO on the same edge.
    task automatic issue_exp(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                             input logic [63:0] res, input int mt, input logic [31:0] wd);
        exp_t e;
        wait_idle();
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        hi_we = (mt == 1);
        lo_we = (mt == 2);
        wdata = wd;
        e.hi  = res[63:32];
        e.lo  = res[31:0];
        e.drive_cyc = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        a     = $urandom;
        b     = $urandom;
        op    = 2'($urandom_range(0, 3));
        if (mt == 1) chk("mthi_same_edge_as_start", {32'b0, hi}, {32'b0, wd});
        if (mt == 2) chk("mtlo_same_edge_as_start", {32'b0, lo}, {32'b0, wd});
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int mt);
        issue_exp(o, x, y, model(o, x, y), mt, $urandom);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'd1;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = $urandom_range(0, 20);
            5: v = -$urandom_range(1, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_done", {63'b0, done}, 64'd0);
        chk("reset_hi", {32'b0, hi}, 64'd0);
        chk("reset_lo", {32'b0, lo}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases with hand-computed results
        issue_exp(2'b00, 32'hFFFF_FFFD, 32'd7,        64'hFFFF_FFFF_FFFF_FFEB, 0, 0);
        issue_exp(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 0, 0);
        issue_exp(2'b10, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 0, 0);
        issue_exp(2'b11, 32'd7,         32'd2,        64'h0000_0001_0000_0003, 0, 0);
        issue_exp(2'b11, 32'h0000_1234, 32'd0,        64'h0000_1234_FFFF_FFFF, 1, 32'h1111);
        issue_exp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 2, 32'h2222);
        issue_exp(2'b10, 32'h8000_0000, 32'd0,        64'h8000_0000_FFFF_FFFF, 0, 0);
        issue_exp(2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 0);
        drain();

        // Start and MTHI while busy are ignored; MTLO in idle takes effect
        issue_exp(2'b00, 32'd6, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFE8, 0, 0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 2'b11;
        a     = 32'd100;
        b     = 32'd3;
        hi_we = 1'b1;
        wdata = 32'hAA;
        @(negedge clk);
        start = 1'b0;
        hi_we = 1'b0;
        drain();
        chk("idle_after_ignored_start", {63'b0, busy}, 64'd0);
        lo_we = 1'b1;
        wdata = 32'h55;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_idle", {32'b0, lo}, 64'h55);
        chk("mtlo_keeps_hi", {32'b0, hi}, 64'hFFFF_FFFF);

        // Randomized ops, mixing back-to-back launches and idle gaps
        for (int i = 0; i < 60; i++) begin
            issue(2'($urandom_range(0, 3)), pick(), pick(),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0);
            if ($urandom_range(0, 2) == 0) begin
                wait_idle();
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        drain();

        // Reset in the middle of a DIV aborts it without a done pulse
        issue(2'b10, 32'd1000, 32'd7, 0);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midop_reset_busy", {63'b0, busy}, 64'd0);
        chk("midop_reset_done", {63'b0, done}, 64'd0);
        chk("midop_reset_hi", {32'b0, hi}, 64'd0);
        chk("midop_reset_lo", {32'b0, lo}, 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("no_done_after_reset_lo", {32'b0, lo}, 64'd0);
        chk("no_restart_after_reset", {63'b0, busy}, 64'd0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
        $finish;
    end

endmodule
